// File: rtl/tia_hsync_counter.sv
// tia_hsync_counter: colour-clock /4 two-phase clock, 57-state LFSR line counter and HSYNC/CBURST/HBLANK decode.
// Optional TIA_HSYNC_LATE_HBLANK_EN adds hmove_late, which stretches HBLANK from S16 to S18.
module tia_hsync_counter (
  input  logic       clk,
  input  logic       rsyn,
`ifdef TIA_HSYNC_LATE_HBLANK_EN
  input  logic       hmove_late,
`endif
  output logic       hphi1,
  output logic       hphi2,
  output logic [5:0] hcount,
  output logic       line_start,
  output logic       hsync,
  output logic       cburst,
  output logic       hblank,
  output logic       center
);
  localparam logic [5:0] S0  = 6'b000000;
  localparam logic [5:0] S4  = 6'b001111;
  localparam logic [5:0] S8  = 6'b111011;
  localparam logic [5:0] S12 = 6'b111100;
  localparam logic [5:0] S16 = 6'b001110;
  localparam logic [5:0] S36 = 6'b001101;
  localparam logic [5:0] S56 = 6'b001010;
`ifdef TIA_HSYNC_LATE_HBLANK_EN
  localparam logic [5:0] S18 = 6'b111010;
`endif
  logic       run_q;
  logic [1:0] phase_q, phase_d;
  logic [5:0] hcount_q, hcount_d;
  logic       hphi1_q, hphi2_q, line_start_q, line_start_d;
  logic       hsync_q, hsync_d, cburst_q, cburst_d, hblank_q, hblank_d;
  logic       adv, dec, blank_end;
  // run_q holds the phase at 0 for the first edge after reset so cycle 0 starts on phase 0 with hphi1 high
  always_comb begin
    phase_d      = run_q ? phase_q + 2'd1 : phase_q;
    adv          = run_q && (phase_q == 2'd2);
    dec          = run_q && (phase_q == 2'd0);
    hcount_d     = !adv ? hcount_q :
                   (hcount_q == S56) ? S0 : {hcount_q[4:0], ~(hcount_q[5] ^ hcount_q[4])};
    line_start_d = adv && (hcount_q == S56);
`ifdef TIA_HSYNC_LATE_HBLANK_EN
    blank_end    = dec && (((hcount_q == S16) && !hmove_late) || (hcount_q == S18));
`else
    blank_end    = dec && (hcount_q == S16);
`endif
    hsync_d      = (dec && hcount_q == S4) ? 1'b1 : (dec && hcount_q == S8) ? 1'b0 : hsync_q;
    cburst_d     = (dec && hcount_q == S8) ? 1'b1 : (dec && hcount_q == S12) ? 1'b0 : cburst_q;
    hblank_d     = (dec && hcount_q == S0) ? 1'b1 : blank_end ? 1'b0 : hblank_q;
  end
  always_ff @(posedge clk) begin
    if (rsyn) begin
      run_q        <= 1'b0;
      phase_q      <= 2'd0;
      hcount_q     <= S0;
      hphi1_q      <= 1'b0;
      hphi2_q      <= 1'b0;
      line_start_q <= 1'b0;
      hsync_q      <= 1'b0;
      cburst_q     <= 1'b0;
      hblank_q     <= 1'b1;
    end else begin
      run_q        <= 1'b1;
      phase_q      <= phase_d;
      hcount_q     <= hcount_d;
      hphi1_q      <= (phase_d == 2'd0);
      hphi2_q      <= (phase_d == 2'd2);
      line_start_q <= line_start_d;
      hsync_q      <= hsync_d;
      cburst_q     <= cburst_d;
      hblank_q     <= hblank_d;
    end
  end
  assign hphi1      = hphi1_q;
  assign hphi2      = hphi2_q;
  assign hcount     = hcount_q;
  assign line_start = line_start_q;
  assign hsync      = hsync_q;
  assign cburst     = cburst_q;
  assign hblank     = hblank_q;
  assign center     = (hcount_q == S36);
endmodule

// File: tb/tb_tia_hsync_counter.sv
// tb_tia_hsync_counter: scoreboard bench for tia_hsync_counter; expected output vectors come from a cycle-indexed line timeline.
module tb_tia_hsync_counter;
  logic       clk = 1'b0;
  logic       rsyn = 1'b1;
  logic       hphi1, hphi2, line_start, hsync, cburst, hblank, center;
  logic [5:0] hcount;
`ifdef TIA_HSYNC_LATE_HBLANK_EN
  logic       hmove_late = 1'b0;
  int         lc0 = -9, lc1 = -9;
`endif
  always #5 clk = ~clk;
  tia_hsync_counter dut (
    .clk(clk), .rsyn(rsyn),
`ifdef TIA_HSYNC_LATE_HBLANK_EN
    .hmove_late(hmove_late),
`endif
    .hphi1(hphi1), .hphi2(hphi2), .hcount(hcount), .line_start(line_start),
    .hsync(hsync), .cburst(cburst), .hblank(hblank), .center(center)
  );
  logic [12:0] dut_v;
  assign dut_v = {hphi1, hphi2, hcount, line_start, hsync, cburst, hblank, center};
  localparam logic [12:0] RST_V = 13'b0_0_000000_0_0_0_1_0;
  int          n_cmp = 0, n_bad = 0, cyc = -1;
  bit          late_line = 1'b0;
  logic [5:0]  lfsr_tab [57];
  logic [12:0] q [$];
  function automatic logic [12:0] exp_at(int c, bit late);
    int cm = c % 228;
    int fall = late ? 73 : 65;
    logic [5:0] h = lfsr_tab[((cm + 1) / 4) % 57];
    logic bl = (c == 0) || (cm >= 1 && cm < fall);
    return {cm % 4 == 0, cm % 4 == 2, h, cm == 227, cm >= 17 && cm <= 32,
            cm >= 33 && cm <= 48, bl, cm >= 143 && cm <= 146};
  endfunction
  task automatic step(input bit rs);
    rsyn = rs;
`ifdef TIA_HSYNC_LATE_HBLANK_EN
    hmove_late = !rs && (cyc == lc0 || cyc == lc1);
`endif
    cyc = rs ? -1 : cyc + 1;
    q.push_back(rs ? RST_V : exp_at(cyc, late_line));
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rsyn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc = -1;
    q.delete();
  endtask
  task automatic test_reset();
    logic [12:0] e;
    rsyn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (dut_v !== RST_V) begin n_bad++; $display("FAIL reset i=%0d got=%b exp=%b", i, dut_v, RST_V); end
    end
    cyc = -1;
    step(1'b0);
    e = q.pop_front();
    n_cmp++;
    if (dut_v !== e) begin n_bad++; $display("FAIL cycle0 got=%b exp=%b", dut_v, e); end
  endtask
  task automatic test_phases();
    logic [12:0] e;
    for (int i = 1; i < 12; i++) begin
      step(1'b0);
      e = q.pop_front();
      n_cmp++;
      if (dut_v !== e) begin n_bad++; $display("FAIL phases c=%0d got=%b exp=%b", cyc, dut_v, e); end
    end
  endtask
  task automatic test_lfsr();
    logic [12:0] e;
    int ck_c [6] = '{3, 7, 11, 15, 223, 227};
    logic [5:0] ck_h [6] = '{6'b000001, 6'b000011, 6'b000111, 6'b001111, 6'b001010, 6'b000000};
    late_line = 1'b0;
    do_reset();
    for (int i = 0; i < 230; i++) begin
      step(1'b0);
      e = q.pop_front();
      n_cmp++;
      if (dut_v !== e) begin n_bad++; $display("FAIL lfsr_line c=%0d got=%b exp=%b", cyc, dut_v, e); end
      for (int k = 0; k < 6; k++)
        if (cyc == ck_c[k]) begin
          n_cmp++;
          if (hcount !== ck_h[k]) begin n_bad++; $display("FAIL hcount c=%0d got=%b exp=%b", cyc, hcount, ck_h[k]); end
        end
      if (cyc == 227) begin
        n_cmp++;
        if (line_start !== 1'b1) begin n_bad++; $display("FAIL line_start227 got=%b exp=1", line_start); end
      end
    end
  endtask
  task automatic test_windows();
    logic [12:0] e;
    int ns = 0, nb = 0, nc = 0, first_s = -1;
    for (int i = 0; i < 228; i++) begin
      step(1'b0);
      e = q.pop_front();
      n_cmp++;
      if (dut_v !== e) begin n_bad++; $display("FAIL windows c=%0d got=%b exp=%b", cyc, dut_v, e); end
      ns += int'(hsync);
      nb += int'(cburst);
      nc += int'(center);
      if (hsync === 1'b1 && first_s < 0) first_s = cyc;
    end
    n_cmp += 4;
    if (ns != 16) begin n_bad++; $display("FAIL hsync_len got=%0d exp=16", ns); end
    if (nb != 16) begin n_bad++; $display("FAIL cburst_len got=%0d exp=16", nb); end
    if (nc != 4) begin n_bad++; $display("FAIL center_len got=%0d exp=4", nc); end
    if (first_s != 228 + 17) begin n_bad++; $display("FAIL hsync_rise got=%0d exp=%0d", first_s, 228 + 17); end
  endtask
  task automatic test_hblank(input bit late);
    logic [12:0] e;
    int fall = late ? 73 : 65;
    late_line = late;
    do_reset();
    for (int i = 0; i < 230; i++) begin
      step(1'b0);
      e = q.pop_front();
      n_cmp++;
      if (dut_v !== e) begin n_bad++; $display("FAIL hblank_line late=%0d c=%0d got=%b exp=%b", late, cyc, dut_v, e); end
      if (cyc == fall - 1 || cyc == fall || cyc == 228 || cyc == 229) begin
        n_cmp++;
        if (hblank !== (cyc == fall - 1 || cyc == 229))
          begin n_bad++; $display("FAIL hblank_edge late=%0d c=%0d got=%b", late, cyc, hblank); end
      end
    end
    late_line = 1'b0;
  endtask
  task automatic test_midline_reset();
    logic [12:0] e;
    late_line = 1'b0;
    do_reset();
    for (int i = 0; i < 21; i++) begin
      step(1'b0);
      e = q.pop_front();
      n_cmp++;
      if (dut_v !== e) begin n_bad++; $display("FAIL pre_reset c=%0d got=%b exp=%b", cyc, dut_v, e); end
    end
    n_cmp++;
    if (hsync !== 1'b1) begin n_bad++; $display("FAIL hsync_c20 got=%b exp=1", hsync); end
    step(1'b1);
    e = q.pop_front();
    n_cmp++;
    if (dut_v !== e || hsync !== 1'b0 || hblank !== 1'b1 || hcount !== 6'd0)
      begin n_bad++; $display("FAIL midline_reset got=%b exp=%b", dut_v, e); end
    for (int i = 0; i < 230; i++) begin
      step(1'b0);
      e = q.pop_front();
      n_cmp++;
      if (dut_v !== e) begin n_bad++; $display("FAIL post_reset c=%0d got=%b exp=%b", cyc, dut_v, e); end
    end
  endtask
  task automatic test_multiline();
    logic [12:0] e;
    int last = -1, pulses = 0, bad_gap = 0, lockup = 0;
    late_line = 1'b0;
    do_reset();
    for (int i = 0; i < 2281; i++) begin
      step(1'b0);
      e = q.pop_front();
      n_cmp++;
      if (dut_v !== e) begin n_bad++; $display("FAIL multiline c=%0d got=%b exp=%b", cyc, dut_v, e); end
      if (hcount === 6'b111111) lockup++;
      if (line_start === 1'b1) begin
        if (last >= 0 && cyc - last != 228) bad_gap++;
        last = cyc;
        pulses++;
      end
    end
    n_cmp += 3;
    if (pulses != 10) begin n_bad++; $display("FAIL line_start_count got=%0d exp=10", pulses); end
    if (bad_gap != 0) begin n_bad++; $display("FAIL line_start_gap bad=%0d exp=0", bad_gap); end
    if (lockup != 0) begin n_bad++; $display("FAIL hcount_lockup got=%0d exp=0", lockup); end
  endtask
  initial begin
    logic [5:0] h = 6'd0;
    for (int n = 0; n < 57; n++) begin
      lfsr_tab[n] = h;
      h = {h[4:0], ~(h[5] ^ h[4])};
    end
    test_reset();
    test_phases();
    test_lfsr();
    test_windows();
    test_hblank(1'b0);
`ifdef TIA_HSYNC_LATE_HBLANK_EN
    lc0 = 60;
    lc1 = 68;
    test_hblank(1'b0);
    lc0 = 64;
    lc1 = -9;
    test_hblank(1'b1);
    lc0 = -9;
`endif
    test_midline_reset();
    test_multiline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
